// File: rtl/led_matrix_pager_if.sv
// ---------------------------------------------------------------------------
// led_matrix_pager_if
//
// Bundles everything between the debug source (processor / top-level wiring)
// and the LED pager, plus the pins the pager drives toward the board.
//
//   page_data     master -> slave  flattened pages, column c of page p at
//                                  [(p*COLUMNS+c)*ROWS +: ROWS]
//   auto_cycle    master -> slave  1 = advance pages automatically
//   select_valid  master -> slave  one-cycle page jump request
//   select_page   master -> slave  requested page index
//   freeze        master -> slave  level, hold a snapshot while high
//   led_rows      slave -> master  registered row drive
//   led_columns   slave -> master  registered one-hot column enable
//   current_page  slave -> master  page currently displayed
//   frozen        slave -> master  1 while the snapshot is displayed
//   freeze_state  slave -> master  raw state of the freeze FSM (debug)
//
// Handshake: select_valid/select_page form a valid-only request with no ready.
// A request is consumed in the single cycle select_valid is high; a page index
// outside 0..PAGES-1 is dropped without effect. There is no back-pressure.
// ---------------------------------------------------------------------------
interface led_matrix_pager_if #(
  parameter int ROWS    = 8,
  parameter int COLUMNS = 4,
  parameter int PAGES   = 4
);
  localparam int PW = (PAGES > 1) ? $clog2(PAGES) : 1;

  logic [PAGES*COLUMNS*ROWS-1:0] page_data;
  logic                          auto_cycle;
  logic                          select_valid;
  logic [PW-1:0]                 select_page;
  logic                          freeze;
  logic [ROWS-1:0]               led_rows;
  logic [COLUMNS-1:0]            led_columns;
  logic [PW-1:0]                 current_page;
  logic                          frozen;
  logic                          freeze_state;

  modport master (
    output page_data, auto_cycle, select_valid, select_page, freeze,
    input  led_rows, led_columns, current_page, frozen, freeze_state
  );

  modport slave (
    input  page_data, auto_cycle, select_valid, select_page, freeze,
    output led_rows, led_columns, current_page, frozen, freeze_state
  );
endinterface

// File: rtl/led_matrix_pager.sv
// ---------------------------------------------------------------------------
// led_matrix_pager
//
// Time-multiplexes a ROWS x COLUMNS LED matrix one column at a time and shows
// one of PAGES debug pages. Pages advance automatically every PAGE_FRAMES
// frames when auto_cycle is set, or jump on a select request. Raising freeze
// snapshots every page at once so an error state stays readable while the
// source keeps changing; scanning and paging continue over the snapshot.
//
// Ports:
//   clk    system clock, single domain
//   reset  synchronous, active-high
//   bus    led_matrix_pager_if.slave (page data, paging controls, freeze,
//          LED row/column drive, current page, frozen flag, FSM debug state)
//
// All LED outputs are registered. Each register is loaded from the *next*
// scan/page/freeze state so that a column change, its blanking window and a
// page_data change all appear on the pins on the edge that causes them.
// ---------------------------------------------------------------------------
module led_matrix_pager #(
  parameter int ROWS         = 8,
  parameter int COLUMNS      = 4,
  parameter int PAGES        = 4,
  parameter int SCAN_CYCLES  = 1024,
  parameter int BLANK_CYCLES = 16,
  parameter int PAGE_FRAMES  = 64,
  parameter int ACTIVE_LOW   = 1
) (
  input  logic               clk,
  input  logic               reset,
  led_matrix_pager_if.slave  bus
);

  // -------------------------------------------------------------------------
  // Derived widths and sized constants
  // -------------------------------------------------------------------------
  localparam int PW     = (PAGES > 1)       ? $clog2(PAGES)       : 1;
  localparam int CW     = (COLUMNS > 1)     ? $clog2(COLUMNS)     : 1;
  localparam int SW     = (SCAN_CYCLES > 1) ? $clog2(SCAN_CYCLES) : 1;
  localparam int FW     = (PAGE_FRAMES > 1) ? $clog2(PAGE_FRAMES) : 1;
  localparam int NWORDS = PAGES * COLUMNS;
  localparam int IW     = (NWORDS > 1)      ? $clog2(NWORDS)      : 1;
  localparam int TOTAL  = NWORDS * ROWS;

  localparam logic [SW-1:0] SCAN_LAST  = SW'(SCAN_CYCLES - 1);
  localparam logic [CW-1:0] COL_LAST   = CW'(COLUMNS - 1);
  localparam logic [PW-1:0] PAGE_LAST  = PW'(PAGES - 1);
  // The frame counter runs 0..PAGE_FRAMES-1; the advance happens on the
  // boundary that would take it to PAGE_FRAMES.
  localparam logic [FW-1:0] FRAME_LAST = FW'(PAGE_FRAMES - 1);
  // One bit wider than the values compared against, so the limit itself
  // (which may equal 2**width) is representable.
  localparam logic [SW:0]   BLANK_LIM  = (SW+1)'(BLANK_CYCLES);
  localparam logic [PW:0]   PAGE_LIM   = (PW+1)'(PAGES);

  localparam logic [ROWS-1:0]    ROWS_OFF  = (ACTIVE_LOW != 0) ? '1 : '0;
  localparam logic [COLUMNS-1:0] COL0_HOT  = COLUMNS'(1);
  localparam logic [COLUMNS-1:0] COL0_DRV  = (ACTIVE_LOW != 0) ? ~COL0_HOT : COL0_HOT;

  // -------------------------------------------------------------------------
  // Freeze FSM: LIVE shows page_data, FROZEN shows the snapshot.
  // -------------------------------------------------------------------------
  typedef enum logic {
    ST_LIVE   = 1'b0,
    ST_FROZEN = 1'b1
  } freeze_state_t;

  freeze_state_t state_q, state_n;
  logic          snap_load;

  // -------------------------------------------------------------------------
  // Registers
  // -------------------------------------------------------------------------
  logic [SW-1:0]      scan_q;
  logic [CW-1:0]      col_q;
  logic [PW-1:0]      page_q;
  logic [FW-1:0]      frame_q;
  logic [TOTAL-1:0]   snapshot_q;
  logic [ROWS-1:0]    rows_q;
  logic [COLUMNS-1:0] cols_q;

  // -------------------------------------------------------------------------
  // Next-state signals
  // -------------------------------------------------------------------------
  logic [SW-1:0]      scan_n;
  logic [CW-1:0]      col_n;
  logic [PW-1:0]      page_n;
  logic [FW-1:0]      frame_n;
  logic               scan_wrap;
  logic               frame_edge;
  logic               select_ok;
  logic               use_snap;
  logic               blank_n;
  logic [TOTAL-1:0]   src;
  logic [ROWS-1:0]    word_arr [NWORDS];
  logic [IW-1:0]      word_idx;
  logic [ROWS-1:0]    row_word;
  logic [ROWS-1:0]    rows_n;
  logic [COLUMNS-1:0] col_hot;
  logic [COLUMNS-1:0] cols_n;

  // -------------------------------------------------------------------------
  // Freeze FSM next state. Entering FROZEN is the rising edge of freeze as
  // seen from LIVE, so a freeze held through reset counts as a new edge.
  // -------------------------------------------------------------------------
  always_comb begin
    state_n   = state_q;
    snap_load = 1'b0;
    case (state_q)
      ST_LIVE: begin
        if (bus.freeze) begin
          state_n   = ST_FROZEN;
          snap_load = 1'b1;
        end
      end
      ST_FROZEN: begin
        if (!bus.freeze) begin
          state_n = ST_LIVE;
        end
      end
      default: begin
        state_n = ST_LIVE;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // Scan, column and paging next state
  // -------------------------------------------------------------------------
  always_comb begin
    scan_wrap  = (scan_q == SCAN_LAST);
    frame_edge = scan_wrap && (col_q == COL_LAST);
    scan_n     = scan_wrap ? '0 : scan_q + 1'b1;
    col_n      = col_q;
    if (scan_wrap) begin
      col_n = (col_q == COL_LAST) ? '0 : col_q + 1'b1;
    end

    select_ok = bus.select_valid && ({1'b0, bus.select_page} < PAGE_LIM);
    page_n    = page_q;
    frame_n   = frame_q;

    if (PAGES > 1) begin
      if (!bus.auto_cycle) begin
        frame_n = '0;
      end else if (frame_edge) begin
        if (frame_q == FRAME_LAST) begin
          frame_n = '0;
          page_n  = (page_q == PAGE_LAST) ? '0 : page_q + 1'b1;
        end else begin
          frame_n = frame_q + 1'b1;
        end
      end
      // Applied last so an explicit selection overrides a coincident
      // auto-advance in the same cycle.
      if (select_ok) begin
        page_n  = bus.select_page;
        frame_n = '0;
      end
    end else begin
      page_n  = '0;
      frame_n = '0;
    end
  end

  // -------------------------------------------------------------------------
  // Row/column drive for the next cycle.
  //
  // The snapshot is only read when we are frozen now and stay frozen. On the
  // entry edge the snapshot is being loaded from page_data, so page_data is
  // already the same content; on the exit edge live data must show at once.
  // -------------------------------------------------------------------------
  assign use_snap = (state_q == ST_FROZEN) && (state_n == ST_FROZEN);
  assign src      = use_snap ? snapshot_q : bus.page_data;

  for (genvar g = 0; g < NWORDS; g++) begin : g_words
    assign word_arr[g] = src[g*ROWS +: ROWS];
  end

  always_comb begin
    word_idx = IW'(32'(page_n) * COLUMNS + 32'(col_n));
    row_word = word_arr[word_idx];
    blank_n  = ({1'b0, scan_n} < BLANK_LIM);
    if (blank_n) begin
      rows_n = ROWS_OFF;
    end else if (ACTIVE_LOW != 0) begin
      rows_n = ~row_word;
    end else begin
      rows_n = row_word;
    end
    col_hot = COL0_HOT << col_n;
    cols_n  = (ACTIVE_LOW != 0) ? ~col_hot : col_hot;
  end

  // -------------------------------------------------------------------------
  // State registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_LIVE;
      scan_q     <= '0;
      col_q      <= '0;
      page_q     <= '0;
      frame_q    <= '0;
      snapshot_q <= '0;
      rows_q     <= ROWS_OFF;
      cols_q     <= COL0_DRV;
    end else begin
      state_q <= state_n;
      scan_q  <= scan_n;
      col_q   <= col_n;
      page_q  <= page_n;
      frame_q <= frame_n;
      if (snap_load) begin
        snapshot_q <= bus.page_data;
      end
      rows_q <= rows_n;
      cols_q <= cols_n;
    end
  end

  // -------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------
  assign bus.led_rows     = rows_q;
  assign bus.led_columns  = cols_q;
  assign bus.current_page = page_q;
  assign bus.frozen       = (state_q == ST_FROZEN);
  assign bus.freeze_state = state_q;

endmodule
